// File: rtl/parity_frame_rx.sv
// Purpose: parity-framed serial receiver (start, WIDTH data LSB first, parity, stop) to a parallel word. Optional macro PARITY_FRAME_RX_FLAGS_EN adds all_ones/all_zeros.
// Latency: out_valid rises in the cycle after the edge that samples a good stop bit.
// Backpressure: a single valid/ready output register; a frame completing while it is held and not being consumed is dropped and overrun pulses.
module parity_frame_rx #(
  parameter int WIDTH = 4,
  parameter int ODD   = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             rx_en,
  input  logic             rx_in,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             par_err,
  output logic             frm_err,
  output logic             overrun
`ifdef PARITY_FRAME_RX_FLAGS_EN
  ,
  output logic             all_ones,
  output logic             all_zeros
`endif
);

  // Counter must hold 0..WIDTH-1; the +1 keeps WIDTH=1 at a legal 1-bit width.
  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

  state_t           state, state_nxt;
  logic [CW-1:0]    cnt, cnt_nxt;
  logic [WIDTH-1:0] shreg, shreg_nxt;
  logic             par_bit, par_bit_nxt;
  logic             load, drop, bad_stop, err;

  // Next-state, deserialiser update and frame-completion decisions; all moves gated by rx_en.
  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt;
    shreg_nxt   = shreg;
    par_bit_nxt = par_bit;
    load        = 1'b0;
    drop        = 1'b0;
    bad_stop    = 1'b0;
    err         = (^{shreg, par_bit}) ^ (ODD != 0);
    if (rx_en) begin
      case (state)
        IDLE: begin
          if (!rx_in) begin
            state_nxt = DATA;
            cnt_nxt   = '0;
          end
        end
        DATA: begin
          for (int i = 0; i < WIDTH; i++) begin
            if (cnt == CW'(i)) shreg_nxt[i] = rx_in;
          end
          cnt_nxt = cnt + CW'(1);
          if (cnt == CW'(WIDTH - 1)) state_nxt = PARITY;
        end
        PARITY: begin
          par_bit_nxt = rx_in;
          state_nxt   = STOP;
        end
        STOP: begin
          // The output slot counts as free if it is empty or being consumed this cycle.
          if (rx_in) begin
            if (!out_valid || out_ready) load = 1'b1;
            else                         drop = 1'b1;
          end else begin
            bad_stop = 1'b1;
          end
          state_nxt = IDLE;
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  // FSM state, bit counter and shift register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      cnt     <= '0;
      shreg   <= '0;
      par_bit <= 1'b0;
    end else begin
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      shreg   <= shreg_nxt;
      par_bit <= par_bit_nxt;
    end
  end

  // Output register with valid/ready handshake plus one-cycle error pulses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_data  <= '0;
      out_valid <= 1'b0;
      par_err   <= 1'b0;
      frm_err   <= 1'b0;
      overrun   <= 1'b0;
`ifdef PARITY_FRAME_RX_FLAGS_EN
      all_ones  <= 1'b0;
      all_zeros <= 1'b0;
`endif
    end else begin
      frm_err   <= bad_stop;
      overrun   <= drop;
      out_valid <= load | (out_valid & ~out_ready);
      if (load) begin
        out_data  <= shreg;
        par_err   <= err;
`ifdef PARITY_FRAME_RX_FLAGS_EN
        all_ones  <= &shreg;
        all_zeros <= ~|shreg;
`endif
      end
    end
  end

endmodule

// File: tb/tb_parity_frame_rx.sv
// Bench for parity_frame_rx: even-parity and odd-parity instances driven in lockstep.
// Stimulus pushes hand-computed expectations; a negedge monitor pops on each handshake.
// Error pulses are counted by the monitor and checked by the stimulus per scenario.
module tb_parity_frame_rx;

  logic       clk = 1'b0;
  logic       rst_n, rx_en, rx_in, out_ready;
  logic [3:0] out_data, o_data;
  logic       out_valid, par_err, frm_err, overrun;
  logic       o_valid, o_perr, o_frm, o_ovr;
`ifdef PARITY_FRAME_RX_FLAGS_EN
  logic       all_ones, all_zeros, o_ao, o_az;
`endif

  always #5 clk = ~clk;

  parity_frame_rx #(.WIDTH(4), .ODD(0)) dut (
    .clk(clk), .rst_n(rst_n), .rx_en(rx_en), .rx_in(rx_in),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .par_err(par_err), .frm_err(frm_err), .overrun(overrun)
`ifdef PARITY_FRAME_RX_FLAGS_EN
    , .all_ones(all_ones), .all_zeros(all_zeros)
`endif
  );

  parity_frame_rx #(.WIDTH(4), .ODD(1)) dut_odd (
    .clk(clk), .rst_n(rst_n), .rx_en(rx_en), .rx_in(rx_in),
    .out_data(o_data), .out_valid(o_valid), .out_ready(out_ready),
    .par_err(o_perr), .frm_err(o_frm), .overrun(o_ovr)
`ifdef PARITY_FRAME_RX_FLAGS_EN
    , .all_ones(o_ao), .all_zeros(o_az)
`endif
  );

  typedef struct {
    logic [3:0] d;
    logic       pe;
    logic       pe_odd;
    logic       ao;
    logic       az;
  } exp_t;

  exp_t sbq[$];
  int   total = 0;
  int   bad   = 0;
  int   frm_cnt = 0;
  int   ovr_cnt = 0;
  bit   slow = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Expected parity results are hand-derived per frame; flags are a trivial model.
  task automatic push(input logic [3:0] d, input logic pe, input logic pe_odd);
    exp_t e;
    e.d = d; e.pe = pe; e.pe_odd = pe_odd; e.ao = &d; e.az = ~|d;
    sbq.push_back(e);
  endtask

  // Monitor: pops one expectation per accepted frame and tallies error pulses.
  always @(negedge clk) begin
    if (rst_n) begin
      if (frm_err) frm_cnt++;
      if (overrun) ovr_cnt++;
      if (out_valid && out_ready) begin
        if (sbq.size() == 0) begin
          total++; bad++;
          $display("FAIL unexpected_out: got data %0h expected no frame", out_data);
        end else begin
          exp_t e;
          e = sbq.pop_front();
          chk("out_data", out_data, e.d);
          chk("par_err", par_err, e.pe);
          chk("odd_valid", o_valid, 1);
          chk("odd_out_data", o_data, e.d);
          chk("odd_par_err", o_perr, e.pe_odd);
`ifdef PARITY_FRAME_RX_FLAGS_EN
          chk("all_ones", all_ones, e.ao);
          chk("all_zeros", all_zeros, e.az);
`endif
        end
      end
    end
  end

  task automatic send_bit(input logic b);
    if (!slow) begin
      @(posedge clk); #1; rx_en = 1'b1; rx_in = b;
    end else begin
      @(posedge clk); #1; rx_en = 1'b1; rx_in = b;
      @(posedge clk); #1; rx_en = 1'b0; rx_in = ~b;
      @(posedge clk); #1; rx_in = 1'($urandom_range(0, 1));
    end
  endtask

  task automatic send_frame(input logic [3:0] d, input logic p, input logic s);
    send_bit(1'b0);
    for (int i = 0; i < 4; i++) send_bit(d[i]);
    send_bit(p);
    send_bit(s);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) send_bit(1'b1);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_out_data"}, out_data, 0);
    chk({tag, "_out_valid"}, out_valid, 0);
    chk({tag, "_par_err"}, par_err, 0);
    chk({tag, "_frm_err"}, frm_err, 0);
    chk({tag, "_overrun"}, overrun, 0);
    chk({tag, "_odd_valid"}, o_valid, 0);
    chk({tag, "_odd_data"}, o_data, 0);
`ifdef PARITY_FRAME_RX_FLAGS_EN
    chk({tag, "_all_ones"}, all_ones, 0);
    chk({tag, "_all_zeros"}, all_zeros, 0);
`endif
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected test end");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; rx_en = 1'b0; rx_in = 1'b1; out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk_all_zero("reset");
    rst_n = 1'b1;

    // Frame 4'hB, parity 1: even ok, odd instance flags an error. Latency exactly one edge.
    out_ready = 1'b1;
    idle(2);
    push(4'hB, 1'b0, 1'b1);
    send_frame(4'hB, 1'b1, 1'b1);
    chk("lat_before_stop", out_valid, 0);
    send_bit(1'b1);
    chk("lat_after_stop", out_valid, 1);
    chk("lat_data", out_data, 4'hB);
    send_bit(1'b1);
    chk("accept_clears_valid", out_valid, 0);

    // Same data, parity 0: even errors, odd clean.
    push(4'hB, 1'b1, 1'b0);
    send_frame(4'hB, 1'b0, 1'b1);
    idle(2);

    // Bad stop bit: single frm_err pulse, nothing delivered; then frame 4'h5.
    frm_cnt = 0;
    send_frame(4'hB, 1'b1, 1'b0);
    idle(3);
    chk("frm_err_pulses", frm_cnt, 1);
    chk("frm_no_valid", out_valid, 0);
    push(4'h5, 1'b0, 1'b1);
    send_frame(4'h5, 1'b0, 1'b1);
    idle(2);

    // Overrun: 4'h3 held, back-to-back 4'hC dropped.
    out_ready = 1'b0;
    ovr_cnt = 0;
    push(4'h3, 1'b0, 1'b1);
    send_frame(4'h3, 1'b0, 1'b1);
    send_frame(4'hC, 1'b0, 1'b1);
    idle(3);
    chk("overrun_pulses", ovr_cnt, 1);
    chk("overrun_valid_held", out_valid, 1);
    chk("overrun_data_held", out_data, 4'h3);
    out_ready = 1'b1;
    idle(2);

    // Consume in the load cycle: 4'hC replaces 4'h3 with no overrun.
    out_ready = 1'b0;
    ovr_cnt = 0;
    push(4'h3, 1'b0, 1'b1);
    send_frame(4'h3, 1'b0, 1'b1);
    push(4'hC, 1'b0, 1'b1);
    send_frame(4'hC, 1'b0, 1'b1);
    out_ready = 1'b1;
    send_bit(1'b1);
    out_ready = 1'b0;
    chk("load_cycle_valid", out_valid, 1);
    chk("load_cycle_data", out_data, 4'hC);
    idle(2);
    chk("load_cycle_no_overrun", ovr_cnt, 0);
    out_ready = 1'b1;
    idle(2);

    // Strobe every third cycle with glitches between strobes.
    slow = 1'b1;
    push(4'hB, 1'b0, 1'b1);
    send_frame(4'hB, 1'b1, 1'b1);
    idle(2);
    slow = 1'b0;
    @(posedge clk); #1; rx_en = 1'b1; rx_in = 1'b1;
    idle(2);

    // Reset mid-DATA with a held frame: everything clears, then 4'hA received.
    out_ready = 1'b0;
    frm_cnt = 0;
    send_frame(4'h5, 1'b0, 1'b1);
    idle(2);
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b0);
    @(posedge clk); #1;
    rst_n = 1'b0; rx_in = 1'b1;
    #1;
    chk_all_zero("midreset");
    @(posedge clk); #1;
    rst_n = 1'b1; out_ready = 1'b1;
    idle(2);
    push(4'hA, 1'b0, 1'b1);
    send_frame(4'hA, 1'b0, 1'b1);
    idle(3);
    chk("midreset_no_frm_err", frm_cnt, 0);

    // Flag patterns: all ones and all zeros.
    push(4'hF, 1'b0, 1'b1);
    send_frame(4'hF, 1'b0, 1'b1);
    push(4'h0, 1'b0, 1'b1);
    send_frame(4'h0, 1'b0, 1'b1);
    idle(4);

    chk("scoreboard_empty", sbq.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
